// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer.
// Holds the 128-bit cipher state and walks the external round datapath through
// the initial AddRoundKey, NR-1 full rounds and the final round, fetching one
// round key per step over the key_req/key_vld handshake.
// Optional build macro: AES_DECRYPT_EN adds the dec input and inv output and
// reverses the round-key order for decryption.
// Every output is a flop loaded from the next-state decode, so no input reaches
// an output combinationally.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          key_req,
  output logic [KW-1:0] key_idx,
  input  logic          key_vld,
  output logic          sel_init,
  output logic          sel_last,
  input  logic [127:0]  rnd_result,
  output logic [127:0]  state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
`ifdef AES_DECRYPT_EN
  ,
  input  logic          dec,
  output logic          inv
`endif
);

  localparam logic [KW-1:0] NR_K  = KW'(NR);
  localparam logic [KW-1:0] NR_M1 = KW'(NR - 1);
  localparam logic [KW-1:0] ONE_K = KW'(1);
  localparam logic [KW-1:0] ZERO_K = {KW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } fsm_e;

  fsm_e          fsm_r, fsm_s;
  logic [KW-1:0] rnd_cnt_r, rnd_cnt_s;
  logic [127:0]  state_r, state_s;
  logic          dec_r, dec_s;
  logic          dec_in_s;

  logic          in_ready_r, in_ready_s;
  logic          key_req_r, key_req_s;
  logic [KW-1:0] key_idx_r, key_idx_s;
  logic          sel_init_r, sel_init_s;
  logic          sel_last_r, sel_last_s;
  logic          out_valid_r, out_valid_s;
  logic          busy_r, busy_s;

`ifdef AES_DECRYPT_EN
  logic          inv_r, inv_s;
  assign dec_in_s = dec;
`else
  assign dec_in_s = 1'b0;
`endif

  // Next-state logic: advance only on the handshake that the current state waits for.
  always_comb begin
    fsm_s     = fsm_r;
    rnd_cnt_s = rnd_cnt_r;
    state_s   = state_r;
    dec_s     = dec_r;
    case (fsm_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s   = in_data;
          rnd_cnt_s = ZERO_K;
          dec_s     = dec_in_s;
          fsm_s     = ST_INIT;
        end else begin
          fsm_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (key_vld) begin
          state_s   = rnd_result;
          rnd_cnt_s = ONE_K;
          if (NR > 1) begin
            fsm_s = ST_ROUND;
          end else begin
            fsm_s = ST_FINAL;
          end
        end else begin
          fsm_s = ST_INIT;
        end
      end
      ST_ROUND: begin
        if (key_vld) begin
          state_s   = rnd_result;
          rnd_cnt_s = rnd_cnt_r + ONE_K;
          if (rnd_cnt_r == NR_M1) begin
            fsm_s = ST_FINAL;
          end else begin
            fsm_s = ST_ROUND;
          end
        end else begin
          fsm_s = ST_ROUND;
        end
      end
      ST_FINAL: begin
        if (key_vld) begin
          state_s = rnd_result;
          fsm_s   = ST_DONE;
        end else begin
          fsm_s = ST_FINAL;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_s = ST_IDLE;
        end else begin
          fsm_s = ST_DONE;
        end
      end
      default: begin
        fsm_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state so the output flops line up with the FSM flops.
  always_comb begin
    in_ready_s  = 1'b0;
    key_req_s   = 1'b0;
    key_idx_s   = ZERO_K;
    sel_init_s  = 1'b0;
    sel_last_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (fsm_s)
      ST_IDLE: begin
        in_ready_s = 1'b1;
      end
      ST_INIT: begin
        key_req_s  = 1'b1;
        sel_init_s = 1'b1;
        busy_s     = 1'b1;
        key_idx_s  = dec_s ? NR_K : ZERO_K;
      end
      ST_ROUND: begin
        key_req_s = 1'b1;
        busy_s    = 1'b1;
        key_idx_s = dec_s ? (NR_K - rnd_cnt_s) : rnd_cnt_s;
      end
      ST_FINAL: begin
        key_req_s  = 1'b1;
        sel_last_s = 1'b1;
        busy_s     = 1'b1;
        key_idx_s  = dec_s ? ZERO_K : NR_K;
      end
      ST_DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // FSM, round counter, cipher state and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= ST_IDLE;
      rnd_cnt_r   <= ZERO_K;
      state_r     <= 128'h0;
      dec_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      key_req_r   <= 1'b0;
      key_idx_r   <= ZERO_K;
      sel_init_r  <= 1'b0;
      sel_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      fsm_r       <= fsm_s;
      rnd_cnt_r   <= rnd_cnt_s;
      state_r     <= state_s;
      dec_r       <= dec_s;
      in_ready_r  <= in_ready_s;
      key_req_r   <= key_req_s;
      key_idx_r   <= key_idx_s;
      sel_init_r  <= sel_init_s;
      sel_last_r  <= sel_last_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

`ifdef AES_DECRYPT_EN
  // Inverse-datapath select follows the direction latched for the block in flight.
  always_comb begin
    inv_s = 1'b0;
    if (fsm_s != ST_IDLE) begin
      inv_s = dec_s;
    end else begin
      inv_s = 1'b0;
    end
  end

  // Inverse-datapath select flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_r <= 1'b0;
    end else begin
      inv_r <= inv_s;
    end
  end

  assign inv = inv_r;
`endif

  assign in_ready  = in_ready_r;
  assign key_req   = key_req_r;
  assign key_idx   = key_idx_r;
  assign sel_init  = sel_init_r;
  assign sel_last  = sel_last_r;
  assign state     = state_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule
